// File: rtl/fetch_unit_pkg.sv
// Shared processor definitions: default bus widths and fetch FSM encoding.
// Also used by the control unit and the instruction memory model.
package fetch_unit_pkg;

    localparam int ADDR_W_DEF      = 8;
    localparam int DATA_W_DEF      = 8;
    localparam int STACK_DEPTH_DEF = 4;

    typedef enum logic [1:0] {
        FS_IDLE = 2'd0,
        FS_REQ  = 2'd1,
        FS_DONE = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/fetch_unit_ret_stack.sv
// Return-address LIFO: synchronous push, combinational top-of-stack.
// The occupancy counter is one bit wider than the pointer so full/empty never alias.
module ret_stack
    import fetch_unit_pkg::*;
#(
    parameter int WIDTH = ADDR_W_DEF,
    parameter int DEPTH = STACK_DEPTH_DEF
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] push_data,
    output logic [WIDTH-1:0] top,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [CNT_W-1:0] count_q, count_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] top_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign wr_ptr  = count_q[PTR_W-1:0];
    assign top_ptr = wr_ptr - PTR_W'(1);
    assign top     = mem_q[top_ptr];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_comb begin
        count_d = count_q;
        if (do_push) begin
            count_d = count_q + CNT_W'(1);
        end else if (do_pop) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Entries need no reset: they are only readable once pushed.
    always_ff @(posedge clock) begin
        if (do_push) begin
            mem_q[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, IR, return-address stack and the
// req/ack read handshake to instruction memory.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int DATA_W      = DATA_W_DEF,
    parameter int STACK_DEPTH = STACK_DEPTH_DEF
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              ir_load,
    input  logic              pc_load,
    input  logic              jump_en,
    input  logic              call_en,
    input  logic              ret_en,
    input  logic [ADDR_W-1:0] jump_addr,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic [DATA_W-1:0] IR,
    output logic [ADDR_W-1:0] pc,
    output logic              ir_valid,
    output logic              busy,
    output logic              stack_overflow,
    output logic              stack_underflow
);

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] ir_q, ir_d;
    logic              req_q, req_d;
    logic              valid_q, valid_d;
    logic              busy_q, busy_d;
    logic              ovf_q, ovf_d;
    logic              unf_q, unf_d;

    logic              stk_push;
    logic              stk_pop;
    logic [ADDR_W-1:0] stk_top;
    logic              stk_full;
    logic              stk_empty;
    logic [ADDR_W-1:0] pc_inc;

    assign pc_inc = pc_q + ADDR_W'(1);

    ret_stack #(
        .WIDTH (ADDR_W),
        .DEPTH (STACK_DEPTH)
    ) u_ret_stack (
        .clock     (clock),
        .reset     (reset),
        .push      (stk_push),
        .pop       (stk_pop),
        .push_data (pc_inc),
        .top       (stk_top),
        .full      (stk_full),
        .empty     (stk_empty)
    );

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        ir_d    = ir_q;
        req_d   = req_q;
        valid_d = 1'b0;
        busy_d  = busy_q;
        unique case (state_q)
            FS_IDLE: begin
                if (ir_load) begin
                    state_d = FS_REQ;
                    addr_d  = pc_q;
                    req_d   = 1'b1;
                    busy_d  = 1'b1;
                end
            end
            FS_REQ: begin
                if (mem_ack) begin
                    state_d = FS_DONE;
                    ir_d    = mem_rdata;
                    req_d   = 1'b0;
                    busy_d  = 1'b0;
                    valid_d = 1'b1;
                end
            end
            FS_DONE: begin
                state_d = FS_IDLE;
            end
            default: begin
                state_d = FS_IDLE;
            end
        endcase
    end

    // One PC action per cycle; lower-priority requests are dropped.
    always_comb begin
        pc_d     = pc_q;
        ovf_d    = ovf_q;
        unf_d    = unf_q;
        stk_push = 1'b0;
        stk_pop  = 1'b0;
        if (ret_en) begin
            if (stk_empty) begin
                unf_d = 1'b1;
            end else begin
                stk_pop = 1'b1;
                pc_d    = stk_top;
            end
        end else if (call_en) begin
            if (stk_full) begin
                ovf_d = 1'b1;
            end else begin
                stk_push = 1'b1;
            end
            pc_d = jump_addr;
        end else if (jump_en) begin
            pc_d = jump_addr;
        end else if (pc_load) begin
            pc_d = pc_inc;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= FS_IDLE;
            pc_q    <= '0;
            addr_q  <= '0;
            ir_q    <= '0;
            req_q   <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            addr_q  <= addr_d;
            ir_q    <= ir_d;
            req_q   <= req_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    assign pc              = pc_q;
    assign IR              = ir_q;
    assign mem_req         = req_q;
    assign mem_addr        = addr_q;
    assign ir_valid        = valid_q;
    assign busy            = busy_q;
    assign stack_overflow  = ovf_q;
    assign stack_underflow = unf_q;

endmodule
